// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the Wishbone byte-enable RAM slave
package wb_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic int lsb_f(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int sel_w_f(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_be.sv
// rtl/ram_be.sv - single-port synchronous RAM with per-byte write enables, read-first
module ram_be
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [sel_w_f(DATA_WIDTH)-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            data,
  output logic [DATA_WIDTH-1:0]            q
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    r_q <= r_mem[addr];
    if (we) begin
      for (int i = 0; i < sel_w_f(DATA_WIDTH); i++) begin
        if (be[i]) r_mem[addr][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ram_wb_be.sv
// rtl/ram_wb_be.sv - Wishbone B4 classic RAM slave with byte lanes, wait states and ERR
module ram_wb_be
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 20,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int WAIT_STATES    = 0,
  parameter bit ERR_EN         = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           CYC,
  input  logic                           STB,
  input  logic                           WE,
  input  logic [sel_w_f(DATA_WIDTH)-1:0] SEL,
  input  logic [BUS_ADDR_WIDTH-1:0]      ADR,
  input  logic [DATA_WIDTH-1:0]          DAT_W,
  output logic [DATA_WIDTH-1:0]          DAT_R,
  output logic                           ACK,
  output logic                           ERR
);

  localparam int LSB = lsb_f(DATA_WIDTH);
  localparam int SW  = sel_w_f(DATA_WIDTH);
  localparam logic [BUS_ADDR_WIDTH-1:0] ALIGN_MASK = BUS_ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  state_t                  r_state;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_we;
  logic [SW-1:0]           r_sel;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_hold;

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_err;
  logic                    w_req;
  logic                    w_ram_we;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [SW-1:0]           w_ram_be;
  logic [DATA_WIDTH-1:0]   w_ram_data;
  logic [DATA_WIDTH-1:0]   w_q;

  assign w_idx = ADR[ADDR_WIDTH+LSB-1:LSB];
  assign w_err = ERR_EN && (((ADR & ALIGN_MASK) != '0) || ((ADR >> (ADDR_WIDTH + LSB)) != '0));
  assign w_req = (r_state == IDLE) && CYC && STB;

  // With no wait states the RAM is driven straight from the bus so the write
  // still lands on the edge that enters RESP.
  assign w_ram_addr = (r_state == IDLE) ? w_idx : r_idx;
  assign w_ram_be   = (r_state == IDLE) ? SEL   : r_sel;
  assign w_ram_data = (r_state == IDLE) ? DAT_W : r_dat;
  assign w_ram_we   = !rst &&
                      ((w_req && (WAIT_STATES == 0) && WE && !w_err) ||
                       ((r_state == WAIT) && CYC && (r_cnt == '0) && r_we && !r_err));

  ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .be   (w_ram_be),
    .addr (w_ram_addr),
    .data (w_ram_data),
    .q    (w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_err   <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= w_idx;
            r_we    <= WE;
            r_sel   <= SEL;
            r_dat   <= DAT_W;
            r_err   <= w_err;
            r_cnt   <= WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
            r_state <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (!CYC)                r_state <= IDLE;
          else if (r_cnt == '0)    r_state <= RESP;
          else                     r_cnt   <= r_cnt - 1'b1;
        end
        RESP: begin
          r_state <= IDLE;
          if (CYC) begin
            if (r_err)      r_hold <= '0;
            else if (!r_we) r_hold <= w_q;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM output is already registered; r_hold keeps the last read word afterwards.
  always_comb begin
    DAT_R = r_hold;
    if (r_state == RESP) begin
      if (r_err)      DAT_R = '0;
      else if (!r_we) DAT_R = w_q;
    end
  end

  assign ACK = CYC && (r_state == RESP) && !r_err;
  assign ERR = CYC && (r_state == RESP) && r_err;

endmodule

// File: tb/tb_ram_wb_be.sv
// tb/tb_ram_wb_be.sv - self-checking bench for ram_wb_be (WAIT_STATES 0 and 3 instances)
module tb_ram_wb_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc0 = 1'b0, cyc3 = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic [31:0] dat_r0, dat_r3;
  logic        ack0, err0, ack3, err3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_wb_be #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .CYC(cyc0), .STB(stb), .WE(we), .SEL(sel),
    .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r0), .ACK(ack0), .ERR(err0)
  );

  ram_wb_be #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .CYC(cyc3), .STB(stb), .WE(we), .SEL(sel),
    .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r3), .ACK(ack3), .ERR(err3)
  );

  task automatic txn(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] wd, output int n, output logic ga, output logic ge,
                     output logic [31:0] rd);
    @(posedge clk); #1;
    if (d == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
    stb = 1'b1; we = w; sel = s; adr = a; dat_w = wd;
    ga = 1'b0; ge = 1'b0; rd = '0; n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d == 0) begin ga = ack0; ge = err0; rd = dat_r0; end
      else        begin ga = ack3; ge = err3; rd = dat_r3; end
      if (ga || ge) break;
      n++;
    end
    @(posedge clk); #1;
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
    checks++; if (dat_r0 !== 32'h0) begin failures++; $display("FAIL reset_dat_r0 got=%h exp=0", dat_r0); end
    checks++; if (ack3 !== 1'b0 || err3 !== 1'b0) begin failures++; $display("FAIL reset_ack_err3 got=%b%b exp=00", ack3, err3); end
    checks++; if (dat_r3 !== 32'h0) begin failures++; $display("FAIL reset_dat_r3 got=%h exp=0", dat_r3); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int n; logic ga, ge; logic [31:0] rd;
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, n, ga, ge, rd);
    checks++; if (ga !== 1'b1 || ge !== 1'b0) begin failures++; $display("FAIL basic_wr_ack got=%b%b exp=10", ga, ge); end
    checks++; if (n != 1) begin failures++; $display("FAIL basic_wr_lat got=%0d exp=1", n); end
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, n, ga, ge, rd);
    checks++; if (ga !== 1'b1 || n != 1) begin failures++; $display("FAIL basic_rd_ack got=%b lat=%0d exp=1 lat=1", ga, n); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
    @(negedge clk);
    checks++; if (dat_r0 !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_hold got=%h exp=deadbeef", dat_r0); end
  endtask

  task automatic test_byte_lanes();
    int n; logic ga, ge; logic [31:0] rd;
    txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, n, ga, ge, rd);
    txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, n, ga, ge, rd);
    checks++; if (ga !== 1'b1) begin failures++; $display("FAIL lanes_wr_ack got=%b exp=1", ga); end
    @(negedge clk);
    checks++; if (dat_r0 !== 32'hDEADBEEF) begin failures++; $display("FAIL lanes_hold_after_wr got=%h exp=deadbeef", dat_r0); end
    txn(0, 1'b0, 4'h1, 32'h20, 32'h0, n, ga, ge, rd);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL lanes_rd got=%h exp=11bb33dd", rd); end
    txn(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, n, ga, ge, rd);
    checks++; if (ga !== 1'b1 || ge !== 1'b0) begin failures++; $display("FAIL sel0_ack got=%b%b exp=10", ga, ge); end
    txn(0, 1'b0, 4'hF, 32'h20, 32'h0, n, ga, ge, rd);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL sel0_unchanged got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_wait_states();
    int n; logic ga, ge; logic [31:0] rd;
    txn(1, 1'b1, 4'hF, 32'h40, 32'h55667788, n, ga, ge, rd);
    checks++; if (ga !== 1'b1 || n != 4) begin failures++; $display("FAIL ws_wr got=%b lat=%0d exp=1 lat=4", ga, n); end
    txn(1, 1'b0, 4'hF, 32'h40, 32'h0, n, ga, ge, rd);
    checks++; if (ga !== 1'b1 || ge !== 1'b0 || n != 4) begin failures++; $display("FAIL ws_rd_lat got=%b%b lat=%0d exp=10 lat=4", ga, ge, n); end
    checks++; if (rd !== 32'h55667788) begin failures++; $display("FAIL ws_rd_data got=%h exp=55667788", rd); end
  endtask

  task automatic test_errors();
    int n; logic ga, ge; logic [31:0] rd;
    txn(0, 1'b1, 4'hF, 32'h0, 32'h01020304, n, ga, ge, rd);
    txn(0, 1'b1, 4'hF, 32'h00000002, 32'hFFFFFFFF, n, ga, ge, rd);
    checks++; if (ge !== 1'b1 || ga !== 1'b0 || n != 1) begin failures++; $display("FAIL err_misaligned got=ack%b err%b lat=%0d exp=ack0 err1 lat=1", ga, ge, n); end
    txn(0, 1'b1, 4'hF, 32'h00400000, 32'hFFFFFFFF, n, ga, ge, rd);
    checks++; if (ge !== 1'b1 || ga !== 1'b0 || n != 1) begin failures++; $display("FAIL err_range got=ack%b err%b lat=%0d exp=ack0 err1 lat=1", ga, ge, n); end
    txn(0, 1'b0, 4'hF, 32'h0, 32'h0, n, ga, ge, rd);
    checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL err_word0_kept got=%h exp=01020304", rd); end
    txn(0, 1'b0, 4'hF, 32'h00400000, 32'h0, n, ga, ge, rd);
    checks++; if (ge !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_rd got=err%b dat=%h exp=err1 dat=0", ge, rd); end
  endtask

  task automatic test_abort();
    int n; logic ga, ge; logic [31:0] rd; logic seen;
    txn(1, 1'b1, 4'hF, 32'h80, 32'h12345678, n, ga, ge, rd);
    @(posedge clk); #1;
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h80; dat_w = 32'hCAFEF00D;
    @(posedge clk); #1;
    cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack3 || err3) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_resp got=%b exp=0", seen); end
    txn(1, 1'b0, 4'hF, 32'h80, 32'h0, n, ga, ge, rd);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL abort_old_value got=%h exp=12345678", rd); end
  endtask

  task automatic test_reset_mid();
    int n; logic ga, ge; logic [31:0] rd;
    txn(1, 1'b1, 4'hF, 32'h84, 32'h0BADF00D, n, ga, ge, rd);
    txn(1, 1'b0, 4'hF, 32'h84, 32'h0, n, ga, ge, rd);
    @(posedge clk); #1;
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h84; dat_w = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    checks++; if (ack3 !== 1'b0 || err3 !== 1'b0) begin failures++; $display("FAIL rstmid_ack_err got=%b%b exp=00", ack3, err3); end
    checks++; if (dat_r3 !== 32'h0) begin failures++; $display("FAIL rstmid_dat_r got=%h exp=0", dat_r3); end
    txn(1, 1'b0, 4'hF, 32'h84, 32'h0, n, ga, ge, rd);
    checks++; if (ga !== 1'b1 || n != 4) begin failures++; $display("FAIL rstmid_next_txn got=%b lat=%0d exp=1 lat=4", ga, n); end
    checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL rstmid_not_committed got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_back_to_back();
    int n; logic ga, ge; logic [31:0] rd;
    @(posedge clk); #1;
    cyc0 = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h30; dat_w = 32'h0000AAAA;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL b2b_first_ack got=%b exp=1", ack0); end
    @(posedge clk); #1;
    adr = 32'h34; dat_w = 32'h0000BBBB;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL b2b_second_ack got=%b exp=1", ack0); end
    @(posedge clk); #1;
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0;
    txn(0, 1'b0, 4'hF, 32'h30, 32'h0, n, ga, ge, rd);
    checks++; if (rd !== 32'h0000AAAA) begin failures++; $display("FAIL b2b_rd0 got=%h exp=0000aaaa", rd); end
    txn(0, 1'b0, 4'hF, 32'h34, 32'h0, n, ga, ge, rd);
    checks++; if (rd !== 32'h0000BBBB) begin failures++; $display("FAIL b2b_rd1 got=%h exp=0000bbbb", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
